// File: rtl/fcr_pkg.sv
// Shared FCR link constants, FSM encoding and command-frame byte selection.
// Used by the initiator and by the fcr_ctrl responder.
package fcr_pkg;

  localparam logic [7:0] FCR_OP_RD = 8'h01;
  localparam logic [7:0] FCR_OP_WR = 8'h02;
  localparam logic [7:0] FCR_ACK   = 8'h06;

  localparam logic [2:0] FCR_RD_LEN = 3'd3;
  localparam logic [2:0] FCR_WR_LEN = 3'd5;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StCmdReq  = 3'd1;
  localparam logic [2:0] StCmdGap  = 3'd2;
  localparam logic [2:0] StRspWait = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

  // Byte idx of a command frame; reads only ever use idx 0..2.
  function automatic logic [7:0] fcr_cmd_byte(input logic [2:0]  idx,
                                              input logic        wr,
                                              input logic [15:0] addr,
                                              input logic [15:0] wr_data);
    logic [7:0] b;
    case (idx)
      3'd0:    b = wr ? FCR_OP_WR : FCR_OP_RD;
      3'd1:    b = addr[15:8];
      3'd2:    b = addr[7:0];
      3'd3:    b = wr_data[15:8];
      3'd4:    b = wr_data[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/fcr_byte_sender.sv
// Req/ack sequencing for a single FCR command byte: load raises req with the byte,
// an ack seen while req is high drops req on that edge.
module fcr_byte_sender (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_byte,
  input  logic       ack,
  output logic       req,
  output logic [7:0] data,
  output logic       sent
);

  logic       req_q, req_d;
  logic [7:0] data_q, data_d;

  always_comb begin
    req_d  = req_q;
    data_d = data_q;
    if (load) begin
      req_d  = 1'b1;
      data_d = load_byte;
    end else if (req_q && ack) begin
      req_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q  <= 1'b0;
      data_q <= 8'h00;
    end else begin
      req_q  <= req_d;
      data_q <= data_d;
    end
  end

  assign req  = req_q;
  assign data = data_q;
  assign sent = req_q & ack;

endmodule

// File: rtl/fcr_initiator.sv
// Host-side FCR initiator: serialises one register read/write into command bytes
// and collects the response bytes, with a per-byte response timeout.
module fcr_initiator
  import fcr_pkg::*;
#(
  parameter int unsigned P_TIMEOUT_CLKS = 50_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        err_timeout,
  output logic        err_bad_rsp,
  output logic        cmd_byte_req,
  output logic [7:0]  cmd_byte_data,
  input  logic        cmd_byte_ack,
  input  logic        rsp_byte_req,
  input  logic [7:0]  rsp_byte_data,
  output logic        rsp_byte_ack
);

  localparam int unsigned     CntW    = $clog2(P_TIMEOUT_CLKS) + 1;
  localparam logic [CntW-1:0] TmoLast = CntW'(P_TIMEOUT_CLKS - 1);

  logic [2:0]      state_q, state_d;
  logic            wr_q, wr_d;
  logic [15:0]     addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [2:0]      idx_q, idx_d;
  logic            rsp_idx_q, rsp_idx_d;
  logic [7:0]      shadow_q, shadow_d;
  logic [15:0]     rd_data_q, rd_data_d;
  logic            err_to_q, err_to_d;
  logic            err_bad_q, err_bad_d;
  logic [CntW-1:0] tmo_q, tmo_d;
  logic            rsp_ack_q, rsp_ack_d;

  logic       load;
  logic [7:0] load_byte;
  logic       sent;
  logic       take;
  logic [2:0] last_idx;

  // Any presented byte is taken unless we acked last cycle; outside RspWait it is dropped.
  assign take     = rsp_byte_req & ~rsp_ack_q;
  assign last_idx = (wr_q ? FCR_WR_LEN : FCR_RD_LEN) - 3'd1;

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    idx_d     = idx_q;
    rsp_idx_d = rsp_idx_q;
    shadow_d  = shadow_q;
    rd_data_d = rd_data_q;
    err_to_d  = err_to_q;
    err_bad_d = err_bad_q;
    tmo_d     = '0;
    rsp_ack_d = take;
    load      = 1'b0;
    load_byte = fcr_cmd_byte(idx_q, wr_q, addr_q, wdata_q);

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StCmdReq;
          wr_d      = wr;
          addr_d    = addr;
          wdata_d   = wr_data;
          idx_d     = 3'd0;
          err_to_d  = 1'b0;
          err_bad_d = 1'b0;
          load      = 1'b1;
          load_byte = fcr_cmd_byte(3'd0, wr, addr, wr_data);
        end
      end
      StCmdReq: begin
        if (sent) begin
          if (idx_q == last_idx) begin
            state_d   = StRspWait;
            rsp_idx_d = 1'b0;
          end else begin
            state_d = StCmdGap;
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      StCmdGap: begin
        load    = 1'b1;
        state_d = StCmdReq;
      end
      StRspWait: begin
        if (take) begin
          if (wr_q) begin
            err_bad_d = (rsp_byte_data != FCR_ACK);
            state_d   = StDone;
          end else if (!rsp_idx_q) begin
            shadow_d  = rsp_byte_data;
            rsp_idx_d = 1'b1;
          end else begin
            // Commit only on a complete response so a timeout leaves rd_data intact.
            rd_data_d = {shadow_q, rsp_byte_data};
            state_d   = StDone;
          end
        end else if (tmo_q == TmoLast) begin
          err_to_d = 1'b1;
          state_d  = StDone;
        end else begin
          tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      wr_q      <= 1'b0;
      addr_q    <= 16'h0000;
      wdata_q   <= 16'h0000;
      idx_q     <= 3'd0;
      rsp_idx_q <= 1'b0;
      shadow_q  <= 8'h00;
      rd_data_q <= 16'h0000;
      err_to_q  <= 1'b0;
      err_bad_q <= 1'b0;
      tmo_q     <= '0;
      rsp_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      idx_q     <= idx_d;
      rsp_idx_q <= rsp_idx_d;
      shadow_q  <= shadow_d;
      rd_data_q <= rd_data_d;
      err_to_q  <= err_to_d;
      err_bad_q <= err_bad_d;
      tmo_q     <= tmo_d;
      rsp_ack_q <= rsp_ack_d;
    end
  end

  fcr_byte_sender u_sender (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_byte (load_byte),
    .ack       (cmd_byte_ack),
    .req       (cmd_byte_req),
    .data      (cmd_byte_data),
    .sent      (sent)
  );

  assign busy         = (state_q == StCmdReq) || (state_q == StCmdGap) || (state_q == StRspWait);
  assign done         = (state_q == StDone);
  assign rd_data      = rd_data_q;
  assign err_timeout  = err_to_q;
  assign err_bad_rsp  = err_bad_q;
  assign rsp_byte_ack = rsp_ack_q;

endmodule

// File: tb/tb_fcr_initiator.sv
// Scoreboard bench for fcr_initiator: a driver queues expected frames/results, a
// behavioural responder serves the link, and a monitor compares at each event.
module tb_fcr_initiator;

  localparam int unsigned P = 100;

  logic        clk = 1'b0;
  logic        rst, start, wr;
  logic [15:0] addr, wr_data;
  logic        busy, done;
  logic [15:0] rd_data;
  logic        err_timeout, err_bad_rsp;
  logic        cmd_byte_req;
  logic [7:0]  cmd_byte_data;
  logic        cmd_byte_ack;
  logic        rsp_byte_req;
  logic [7:0]  rsp_byte_data;
  logic        rsp_byte_ack;

  typedef struct {
    logic [15:0] rd;
    logic        to;
    logic        bad;
    int          lat;
  } exp_t;

  exp_t       exp_res_q[$];
  logic [7:0] exp_cmd_q[$];
  int         errors = 0;
  int         checks = 0;

  // Written by the monitor only.
  int done_cnt = 0, acc_cnt = 0, rsp_ack_cnt = 0;
  // Written by the driver only.
  int          rsp_mode = 0, ack_limit = 99, max_dly = 0, max_gap = 0, stray_req = 0;
  logic [15:0] rsp_val = 16'h0000;
  logic [7:0]  rsp_code = 8'h06;
  logic [15:0] model_rd = 16'h0000;

  always #5 clk = ~clk;

  fcr_initiator #(.P_TIMEOUT_CLKS(P)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .wr            (wr),
    .addr          (addr),
    .wr_data       (wr_data),
    .busy          (busy),
    .done          (done),
    .rd_data       (rd_data),
    .err_timeout   (err_timeout),
    .err_bad_rsp   (err_bad_rsp),
    .cmd_byte_req  (cmd_byte_req),
    .cmd_byte_data (cmd_byte_data),
    .cmd_byte_ack  (cmd_byte_ack),
    .rsp_byte_req  (rsp_byte_req),
    .rsp_byte_data (rsp_byte_data),
    .rsp_byte_ack  (rsp_byte_ack)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Responder: acks command bytes after a random delay, answers complete frames.
  initial begin
    logic [7:0] rx[$];
    logic [7:0] rsp_q[$];
    int         wait_cnt = 0, gap = 0, stray_seen = 0, len;
    bit         acc, taken;
    cmd_byte_ack  = 1'b0;
    rsp_byte_req  = 1'b0;
    rsp_byte_data = 8'h00;
    forever begin
      @(negedge clk);
      acc   = cmd_byte_req && cmd_byte_ack;
      taken = rsp_byte_req && rsp_byte_ack;
      if (rst) begin
        rx.delete();
        rsp_q.delete();
      end else if (acc) begin
        rx.push_back(cmd_byte_data);
        len = (rx[0] == 8'h02) ? 5 : 3;
        if (rx.size() == len) begin
          if (rsp_mode == 0) begin
            if (rx[0] == 8'h02) rsp_q.push_back(rsp_code);
            else begin
              rsp_q.push_back(rsp_val[15:8]);
              rsp_q.push_back(rsp_val[7:0]);
            end
          end else if (rsp_mode == 2 && rx[0] != 8'h02) begin
            rsp_q.push_back(rsp_val[15:8]);
          end
          rx.delete();
        end
      end
      if (stray_req != stray_seen) begin
        stray_seen = stray_req;
        rsp_q.push_back(8'h5A);
      end
      @(posedge clk);
      #1;
      if (taken && rsp_q.size() > 0) begin
        void'(rsp_q.pop_front());
        gap = $urandom_range(0, max_gap);
      end
      if (cmd_byte_req && !acc) begin
        if (wait_cnt == 0 && rx.size() < ack_limit) cmd_byte_ack = 1'b1;
        else begin
          cmd_byte_ack = 1'b0;
          if (wait_cnt > 0) wait_cnt--;
        end
      end else begin
        // Occasional stray ack while no request is pending must be ignored.
        cmd_byte_ack = !busy && ($urandom_range(0, 3) == 0);
        wait_cnt     = $urandom_range(0, max_dly);
      end
      if (gap > 0) begin
        gap--;
        rsp_byte_req = 1'b0;
      end else begin
        rsp_byte_req  = (rsp_q.size() > 0);
        rsp_byte_data = (rsp_q.size() > 0) ? rsp_q[0] : 8'h00;
      end
    end
  end

  // Monitor: protocol checks and scoreboard comparison, sampled on the falling edge.
  initial begin
    int         ncyc = 0, last_ack = 0, cmd_rd = 0, res_rd = 0;
    logic       prev_req = 1'b0, prev_acc = 1'b0, prev_rack = 1'b0;
    logic [7:0] prev_data = 8'h00;
    exp_t       e;
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst) begin
        cmd_rd    = exp_cmd_q.size();
        res_rd    = exp_res_q.size();
        prev_req  = 1'b0;
        prev_acc  = 1'b0;
        prev_rack = 1'b0;
      end else begin
        if (prev_acc) chk("cmd_gap_req_low", 32'(cmd_byte_req), 32'(0));
        else if (prev_req) begin
          chk("cmd_req_held", 32'(cmd_byte_req), 32'(1));
          chk("cmd_data_stable", 32'(cmd_byte_data), 32'(prev_data));
        end
        if (cmd_byte_req && cmd_byte_ack) begin
          acc_cnt++;
          last_ack = ncyc + 1;
          if (cmd_rd < exp_cmd_q.size()) begin
            chk("cmd_byte", 32'(cmd_byte_data), 32'(exp_cmd_q[cmd_rd]));
            cmd_rd++;
          end else chk("cmd_byte_count", 32'(cmd_rd + 1), 32'(exp_cmd_q.size()));
        end
        if (done) begin
          chk("busy_low_at_done", 32'(busy), 32'(0));
          if (res_rd < exp_res_q.size()) begin
            e = exp_res_q[res_rd];
            res_rd++;
            chk("rd_data", 32'(rd_data), 32'(e.rd));
            chk("err_timeout", 32'(err_timeout), 32'(e.to));
            chk("err_bad_rsp", 32'(err_bad_rsp), 32'(e.bad));
            if (e.lat >= 0) chk("timeout_latency", 32'(ncyc - last_ack), 32'(e.lat));
          end else chk("done_count", 32'(res_rd + 1), 32'(exp_res_q.size()));
          done_cnt++;
        end
        if (rsp_byte_ack) begin
          rsp_ack_cnt++;
          chk("rsp_ack_not_back_to_back", 32'(prev_rack), 32'(0));
        end
        prev_req  = cmd_byte_req;
        prev_acc  = cmd_byte_req && cmd_byte_ack;
        prev_data = cmd_byte_data;
        prev_rack = rsp_byte_ack;
      end
    end
  end

  // mode 0: full response; 1: silent; 2: read answers only the high byte.
  task automatic do_txn(input logic w, input logic [15:0] a, input logic [15:0] d, input int mode,
                        input logic [15:0] val, input logic [7:0] code, input bit restart);
    exp_t e;
    int   base;
    exp_cmd_q.push_back(w ? 8'h02 : 8'h01);
    exp_cmd_q.push_back(a[15:8]);
    exp_cmd_q.push_back(a[7:0]);
    if (w) begin
      exp_cmd_q.push_back(d[15:8]);
      exp_cmd_q.push_back(d[7:0]);
    end
    e.to  = 1'b0;
    e.bad = 1'b0;
    e.lat = -1;
    if (mode == 0) begin
      if (w) e.bad = (code != 8'h06);
      else model_rd = val;
    end else begin
      e.to = 1'b1;
      if (mode == 1 || w) e.lat = P;
    end
    e.rd = model_rd;
    exp_res_q.push_back(e);
    rsp_mode = mode;
    rsp_val  = val;
    rsp_code = code;
    base     = done_cnt;
    @(posedge clk);
    #1;
    start   = 1'b1;
    wr      = w;
    addr    = a;
    wr_data = d;
    @(posedge clk);
    #1;
    start   = 1'b0;
    wr      = 1'($urandom);
    addr    = 16'($urandom);
    wr_data = 16'($urandom);
    chk("busy_after_start", 32'(busy), 32'(1));
    chk("req_after_start", 32'(cmd_byte_req), 32'(1));
    if (restart) begin
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      start = 1'b1;
      wr    = ~w;
      addr  = a ^ 16'hFFFF;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    for (int i = 0; i < 600 && done_cnt == base; i++) @(posedge clk);
    chk("done_seen", 32'(done_cnt > base), 32'(1));
    @(posedge clk);
    #1;
    chk("rd_data_held", 32'(rd_data), 32'(model_rd));
  endtask

  initial begin
    int         base, bd, mode, r;
    logic [7:0] code;
    rst     = 1'b1;
    start   = 1'b0;
    wr      = 1'b0;
    addr    = 16'h0000;
    wr_data = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_cmd_req", 32'(cmd_byte_req), 32'(0));
    chk("rst_cmd_data", 32'(cmd_byte_data), 32'(0));
    chk("rst_rsp_ack", 32'(rsp_byte_ack), 32'(0));
    chk("rst_err_timeout", 32'(err_timeout), 32'(0));
    chk("rst_err_bad", 32'(err_bad_rsp), 32'(0));
    chk("rst_rd_data", 32'(rd_data), 32'(0));
    rst = 1'b0;

    do_txn(1'b1, 16'h1234, 16'hBEEF, 0, 16'h0000, 8'h06, 1'b0);
    do_txn(1'b0, 16'h00A5, 16'h0000, 0, 16'hCAFE, 8'h00, 1'b0);
    do_txn(1'b0, 16'h0011, 16'h0000, 1, 16'h0000, 8'h00, 1'b0);
    do_txn(1'b0, 16'h0022, 16'h0000, 2, 16'h7700, 8'h00, 1'b0);
    do_txn(1'b1, 16'h0033, 16'h5555, 0, 16'h0000, 8'h15, 1'b0);

    // Stray response byte while idle, then a start repeated on the 3rd busy cycle.
    base = rsp_ack_cnt;
    bd   = done_cnt;
    stray_req++;
    for (int i = 0; i < 20 && rsp_ack_cnt == base; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("stray_acked_once", 32'(rsp_ack_cnt - base), 32'(1));
    chk("stray_no_done", 32'(done_cnt), 32'(bd));
    do_txn(1'b1, 16'h4321, 16'h0F0F, 0, 16'h0000, 8'h06, 1'b1);
    repeat (30) @(posedge clk);
    chk("restart_ignored", 32'(done_cnt), 32'(bd + 1));

    // Reset while the third command byte is pending.
    ack_limit = 2;
    exp_cmd_q.push_back(8'h01);
    exp_cmd_q.push_back(8'h00);
    base = acc_cnt;
    @(posedge clk);
    #1;
    start = 1'b1;
    wr    = 1'b0;
    addr  = 16'h0042;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 50 && !(acc_cnt >= base + 2 && cmd_byte_req); i++) begin
      @(posedge clk);
      #1;
    end
    chk("byte2_pending", 32'(cmd_byte_req && (acc_cnt == base + 2)), 32'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_req_drop", 32'(cmd_byte_req), 32'(0));
    chk("rst_mid_busy_drop", 32'(busy), 32'(0));
    chk("rst_mid_rd_data", 32'(rd_data), 32'(0));
    rst       = 1'b0;
    model_rd  = 16'h0000;
    ack_limit = 99;
    do_txn(1'b0, 16'h0042, 16'h0000, 0, 16'h9ABC, 8'h00, 1'b0);

    for (int n = 0; n < 40; n++) begin
      max_dly = $urandom_range(0, 3);
      max_gap = $urandom_range(0, 3);
      r       = $urandom_range(0, 9);
      mode    = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      code    = 8'h06;
      if (r == 2) begin
        code = 8'($urandom);
        if (code == 8'h06) code = 8'h07;
      end
      do_txn(1'($urandom), 16'($urandom), 16'($urandom), mode, 16'($urandom), code, 1'b0);
    end

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
